// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the instruction-fetch read port
// and the data load/store port. One transaction is outstanding at a time.
// Data has fixed priority over fetch, except that a saturating starvation
// counter forces a fetch grant after STARVE_LIMIT consecutive data grants
// made while fetch was waiting. Responses return to the port that owns the
// transaction one cycle after the memory response.
// Optional build macro: ARB_PERF_CNT_EN adds three 32-bit performance
// counters (fetch grants, data grants, fetch wait cycles) as extra outputs.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  // instruction fetch port
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] i_rd_data,
  output logic              i_rd_valid,
  // data load/store port
  input  logic              d_rd_en,
  input  logic              d_wr_en,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  input  logic [3:0]        d_wr_mask,
  output logic [DATA_W-1:0] d_rd_data,
  output logic              d_rd_valid,
  output logic              d_wr_done,
  // shared memory side
  output logic              s_req_valid,
  input  logic              s_req_ready,
  output logic              s_req_we,
  output logic [ADDR_W-1:0] s_req_addr,
  output logic [DATA_W-1:0] s_req_wdata,
  output logic [3:0]        s_req_wmask,
  input  logic              s_resp_valid,
  input  logic [DATA_W-1:0] s_resp_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_i_wait
`endif
);

  // Counter wide enough to hold STARVE_LIMIT; at least one bit so a
  // disabled limit (0) still yields a legal vector.
  localparam int               CNT_W      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam bit               STARVE_EN  = (STARVE_LIMIT != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Fetch is encoded as 0 so the reset owner value is 0.
  typedef enum logic [1:0] {
    OWN_FETCH = 2'd0,
    OWN_STORE = 2'd1,
    OWN_LOAD  = 2'd2
  } owner_t;

  state_t           state;
  owner_t           owner;
  logic [CNT_W-1:0] starve_cnt;

  logic grant_fetch;
  logic grant_store;
  logic grant_load;

  // Saturating increment of the starvation counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= STARVE_MAX) begin
      return STARVE_MAX;
    end
    return v + CNT_W'(1);
  endfunction

  // Grant decision, only meaningful in IDLE; first matching rule wins.
  always_comb begin
    grant_fetch = 1'b0;
    grant_store = 1'b0;
    grant_load  = 1'b0;
    if (state == IDLE) begin
      if (i_rd_en && STARVE_EN && (starve_cnt == STARVE_MAX)) begin
        grant_fetch = 1'b1;
      end else if (d_wr_en) begin
        grant_store = 1'b1;
      end else if (d_rd_en) begin
        grant_load = 1'b1;
      end else if (i_rd_en) begin
        grant_fetch = 1'b1;
      end
    end
  end

  // Arbitration FSM: latches the granted request, drives the memory
  // request, captures the response and pulses the owning master.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_FETCH;
      starve_cnt  <= '0;
      s_req_valid <= 1'b0;
      s_req_we    <= 1'b0;
      s_req_addr  <= '0;
      s_req_wdata <= '0;
      s_req_wmask <= 4'h0;
      i_rd_valid  <= 1'b0;
      i_rd_data   <= '0;
      d_rd_valid  <= 1'b0;
      d_rd_data   <= '0;
      d_wr_done   <= 1'b0;
    end else begin
      i_rd_valid <= 1'b0;
      d_rd_valid <= 1'b0;
      d_wr_done  <= 1'b0;
      case (state)
        IDLE: begin
          // Starvation bookkeeping: a fetch grant or an idle fetch port
          // restarts the count; data grants over a waiting fetch add one.
          if (grant_fetch) begin
            starve_cnt <= '0;
          end else if ((grant_store || grant_load) && i_rd_en) begin
            starve_cnt <= sat_inc(starve_cnt);
          end else if (!i_rd_en) begin
            starve_cnt <= '0;
          end

          if (grant_fetch) begin
            owner       <= OWN_FETCH;
            s_req_we    <= 1'b0;
            s_req_addr  <= i_rd_addr;
            s_req_wdata <= '0;
            s_req_wmask <= 4'h0;
            s_req_valid <= 1'b1;
            state       <= REQ;
          end else if (grant_store) begin
            owner       <= OWN_STORE;
            s_req_we    <= 1'b1;
            s_req_addr  <= d_addr;
            s_req_wdata <= d_wr_data;
            s_req_wmask <= d_wr_mask;
            s_req_valid <= 1'b1;
            state       <= REQ;
          end else if (grant_load) begin
            owner       <= OWN_LOAD;
            s_req_we    <= 1'b0;
            s_req_addr  <= d_addr;
            s_req_wdata <= '0;
            s_req_wmask <= 4'h0;
            s_req_valid <= 1'b1;
            state       <= REQ;
          end
        end

        REQ: begin
          // Request fields stay frozen until the memory accepts them.
          if (s_req_ready) begin
            s_req_valid <= 1'b0;
            state       <= RESP;
          end
        end

        RESP: begin
          // Response routed to the owner; the pulse appears next cycle.
          if (s_resp_valid) begin
            state <= IDLE;
            case (owner)
              OWN_FETCH: begin
                i_rd_valid <= 1'b1;
                i_rd_data  <= s_resp_rdata;
              end
              OWN_LOAD: begin
                d_rd_valid <= 1'b1;
                d_rd_data  <= s_resp_rdata;
              end
              OWN_STORE: begin
                d_wr_done <= 1'b1;
              end
              default: begin
              end
            endcase
          end
        end

        default: begin
          state       <= IDLE;
          s_req_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic fetch_busy;
  assign fetch_busy = (state != IDLE) && (owner == OWN_FETCH);

  // Performance counters; wrap naturally at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_i_grants <= 32'd0;
      perf_d_grants <= 32'd0;
      perf_i_wait   <= 32'd0;
    end else begin
      if (grant_fetch) begin
        perf_i_grants <= perf_i_grants + 32'd1;
      end
      if (grant_store || grant_load) begin
        perf_d_grants <= perf_d_grants + 32'd1;
      end
      if (i_rd_en && !fetch_busy && !grant_fetch) begin
        perf_i_wait <= perf_i_wait + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the instruction-fetch read port and the data load/store port of the core.
- Sits between the core's instruction and data memory interfaces and the single memory or bus bridge.
- Grants one transaction at a time (one outstanding) with fixed priority, data over instruction, plus an anti-starvation counter for fetch.
- Routes each response back to the port that owns it.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive data grants tolerated while fetch is pending; 0 disables the anti-starvation rule

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_rd_en  in  1  fetch read request, held until i_rd_valid
- i_rd_addr  in  ADDR_W  fetch address
- i_rd_data  out  DATA_W  fetch data, held until the next fetch response
- i_rd_valid  out  1  one-cycle pulse, fetch data valid
- d_rd_en  in  1  load request, held until d_rd_valid
- d_wr_en  in  1  store request, held until d_wr_done
- d_addr  in  ADDR_W  load/store address
- d_wr_data  in  DATA_W  store data
- d_wr_mask  in  4  store byte enables
- d_rd_data  out  DATA_W  load data, held until the next load response
- d_rd_valid  out  1  one-cycle pulse, load data valid
- d_wr_done  out  1  one-cycle pulse, store acknowledged
- s_req_valid  out  1  shared-memory request valid
- s_req_ready  in  1  shared memory accepts the request
- s_req_we  out  1  1 = write, 0 = read
- s_req_addr  out  ADDR_W  request address
- s_req_wdata  out  DATA_W  write data
- s_req_wmask  out  4  write byte mask; 0 for reads
- s_resp_valid  in  1  response pulse, read data or write acknowledge
- s_resp_rdata  in  DATA_W  read data

Behaviour:
- Reset:
  - State is IDLE; owner and starve_cnt are 0.
  - All outputs are 0, including i_rd_data and d_rd_data.
  - A response arriving after reset is dropped. The memory side is reset on the same reset.
- FSM states: IDLE, REQ, RESP.
- IDLE, grant decision (first matching rule wins):
  1. If i_rd_en and STARVE_LIMIT != 0 and starve_cnt == STARVE_LIMIT, grant fetch.
  2. Else if d_wr_en, grant store.
  3. Else if d_rd_en, grant load.
  4. Else if i_rd_en, grant fetch.
  5. Otherwise stay in IDLE.
- On a grant:
  - Latch owner, we, addr, wdata and wmask into request registers (mask forced to 0 for reads) and go to REQ.
  - Later changes on the master inputs are ignored until the next grant.
- If d_rd_en and d_wr_en are both high, the store wins. The load stays pending.
- REQ:
  - s_req_valid = 1 and all s_req_* fields are stable.
  - On s_req_ready go to RESP. The request is accepted in the same cycle.
- RESP:
  - s_req_valid = 0. Wait for s_resp_valid.
  - In the response cycle r, capture the response and go to IDLE.
  - At r+1, pulse the owner's i_rd_valid, d_rd_valid or d_wr_done, and update the owner's data register for reads.
- A response in IDLE or REQ is a protocol error. It is ignored and produces no pulse.
- Latency:
  - Grant at cycle t gives s_req_valid at t+1.
  - With ready at t+1 and response at t+2, the master pulse is at t+3.
  - The next grant decision is at t+3, so back-to-back transactions are spaced 3 cycles minimum.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each data grant made while i_rd_en is high.
  - Clears on a fetch grant, or in any IDLE cycle with i_rd_en low.
- A master that drops its request after the grant still receives the pulse.
- A request first raised in the master-pulse cycle is seen at the next IDLE decision, which is that same cycle.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- With the macro defined, the block adds these extra outputs:
  - perf_i_grants[31:0], counting fetch grants
  - perf_d_grants[31:0], counting data grants
  - perf_i_wait[31:0], counting cycles with i_rd_en high and owner != fetch (or IDLE without a fetch grant)
- All three counters clear on reset and wrap modulo 2^32.
- Without the macro, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
1. Fetch only, i_rd_addr = 0x1C000000, memory ready immediately, response rdata = 0x02800413 one cycle later -> s_req_addr = 0x1C000000 with s_req_we = 0; i_rd_valid pulses once with i_rd_data = 0x02800413 three cycles after the grant.
2. Store and fetch raised in the same cycle, d_addr = 0x100, d_wr_data = 0xDEADBEEF, d_wr_mask = 0xF -> the store goes first (s_req_we = 1, s_req_wmask = 0xF), then d_wr_done, then the fetch request is issued.
3. d_rd_en held continuously with i_rd_en high, STARVE_LIMIT = 4 -> four load grants, then the fifth grant goes to fetch, then loads resume.
4. s_req_ready held low for 10 cycles -> s_req_valid and all s_req_* fields stay constant; no pulses occur; the transaction completes normally after ready rises.
5. Reset asserted in RESP, then s_resp_valid asserted the following cycle -> the FSM is in IDLE, no valid or done pulse occurs, and all outputs are 0.
6. With ARB_PERF_CNT_EN, run scenario 3 -> perf_i_grants = 1, perf_d_grants = 4, and perf_i_wait equals the fetch-pending cycles counted by the bench.
